int_div_unit: RTL and testbench
===============================

Name: int_div_unit

Overview:
- Iterative RV32M divide/remainder unit. It consumes the IDiv request and Funct3 emitted by the integer ALU control decoder.
- Sits in EX beside the single-cycle IALU. Holds the pipeline stall for the duration of a DIV/DIVU/REM/REMU.
- Returns one XLEN-bit result with a one-cycle done strobe.
- Radix-2 restoring algorithm on magnitudes, with sign fix-up at the end.

Parameters:
- XLEN, 32, operand/result width
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN

Ports:
- CLK  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  asynchronous reset, active-low
- IDiv  in  1  divide request from ALU control; level, held while the instruction sits in EX
- Funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU (bit1 selects remainder, bit0 selects unsigned)
- Rs1_data  in  XLEN  dividend
- Rs2_data  in  XLEN  divisor
- Flush  in  1  kill current operation (branch/exception flush)
- Div_Result  out  XLEN  quotient or remainder; valid only while Div_Done=1
- Div_Done  out  1  one-cycle strobe; result valid
- Div_Stall  out  1  freeze IF/ID/EX; combinational

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, counter=0, internal registers=0; Div_Result=0, Div_Done=0, Div_Stall=0.
- States: IDLE, CALC, DONE.
- Div_Stall = (IDiv & state==IDLE & ~Flush) | (state==CALC).
  - Low in DONE, so the pipeline advances on the DONE cycle.
- IDLE:
  - IDiv=1 and Flush=0 → latch Funct3, |Rs1|, |Rs2|, quotient sign, remainder sign (signed ops only).
  - Divisor==0 → go to DONE. Result: quotient all-ones; remainder = Rs1_data unchanged.
  - Signed op with Rs1=0x80000000 and Rs2=0xFFFFFFFF → go to DONE. Result: quotient 0x80000000; remainder 0.
  - Otherwise → go to CALC with counter=0.
- CALC, one step per cycle:
  - Shift {rem, quo} left by 1, trial-subtract the divisor magnitude.
  - Non-negative result → keep it, set quo[0]=1.
  - counter==XLEN-1 → go to DONE; else counter+1.
- DONE (one cycle):
  - Div_Done=1.
  - Div_Result = selected quo/rem, negated when its latched sign is 1. Quotient sign = sign(Rs1) xor sign(Rs2); remainder sign = sign(Rs1).
  - Always return to IDLE. IDiv is ignored in DONE, so a still-high request does not restart.
- Latency, with IDiv first high in cycle 0:
  - Normal: Div_Done in cycle XLEN+1 (33).
  - Special cases: Div_Done in cycle 1.
  - Back-to-back divides: next accepted in the cycle after DONE.
- Flush:
  - In CALC or DONE: go to IDLE next edge; no Div_Done.
  - In IDLE: blocks acceptance.
- Flush and IDiv high together in IDLE: Flush wins.
- rst_n low mid-CALC: immediate abort; all outputs return to reset values.
- Div_Result is held at its last value outside DONE; consumers must qualify it with Div_Done.
- Operands are captured only in IDLE; Rs1/Rs2 changes during CALC have no effect.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN
- Defined: in IDLE, if |dividend| < |divisor| (unsigned compare of magnitudes, divisor nonzero) → go straight to DONE with quotient 0 and remainder = Rs1_data; latency 1.
- Undefined: such operands take the full XLEN iterations and produce identical results.

Decomposition:
- Package int_div_pkg:
  - Funct3 localparams F3_DIV/F3_DIVU/F3_REM/F3_REMU
  - state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2)
  - XLEN default
- One natural sub-module: int_div_core.
  - Unsigned restoring datapath with rem/quo/divisor registers, one-step logic and counter.
  - Controlled by the top-level FSM, which does magnitude, sign and special-case handling.

Test Plan:
- DIV, Rs1=20, Rs2=3, IDiv held → Div_Stall high cycles 0–32, Div_Done in cycle 33 with Div_Result=6; no restart in cycle 34.
- REM, Rs1=-20 (0xFFFFFFEC), Rs2=3 → Div_Result=0xFFFFFFFE (-2). DIV with the same operands → 0xFFFFFFFA (-6).
- DIVU, Rs2=0, Rs1=0x1234 → Div_Done in cycle 1, Div_Result=0xFFFFFFFF. REMU with the same operands → 0x1234.
- DIV, Rs1=0x80000000, Rs2=0xFFFFFFFF → Div_Done in cycle 1, Div_Result=0x80000000. REM with the same operands → 0.
- DIVU 100/7 with Flush pulsed in cycle 10 → state IDLE in cycle 11, no Div_Done, Div_Stall low. rst_n dropped mid-CALC → all outputs 0 immediately.
- REMU, Rs1=5, Rs2=9 → Div_Result=5; Div_Done in cycle 1 with DIV_EARLY_OUT_EN defined, cycle 33 without.

Source files
------------

// File: rtl/int_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : int_div_pkg
// Description : Shared constants and types for the iterative RV32M
//               divide/remainder unit (Funct3 codes, FSM encoding, defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package int_div_pkg;

    // Default datapath width and iteration counter width (2^CNT_W > XLEN)
    localparam int DIV_XLEN  = 32;
    localparam int DIV_CNT_W = 6;

    // Funct3 codes: bit1 selects remainder, bit0 selects unsigned
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;

    // Control FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/int_div_core.sv
`default_nettype none
// ============================================================================
// Module      : int_div_core
// Description : Unsigned radix-2 restoring divide datapath. Holds the partial
//               remainder, quotient/dividend shift register, divisor magnitude
//               and iteration counter. Exposes the next-step values so the
//               controller can capture the final result on the last step.
// Revision    : 1.0 - initial release
// ============================================================================
module int_div_core
    import int_div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_load,
    input  logic            i_step,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem_next,
    output logic [XLEN-1:0] o_quo_next,
    output logic            o_last
);

    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic [CNT_W-1:0] r_cnt;

    // One extra bit: a shifted remainder can reach 2*divisor-1, which
    // overflows XLEN bits when the divisor magnitude has its MSB set.
    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    assign w_shift = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_shift - {1'b0, r_div};

    // Trial subtraction: keep the difference and set the quotient bit when
    // it does not go negative, otherwise restore the shifted remainder.
    always_comb begin
        o_rem_next = w_shift[XLEN-1:0];
        o_quo_next = {r_quo[XLEN-2:0], 1'b0};
        if (!w_diff[XLEN]) begin
            o_rem_next    = w_diff[XLEN-1:0];
            o_quo_next[0] = 1'b1;
        end
    end

    assign o_last = (r_cnt == CNT_W'(XLEN - 1));

    // Datapath registers: load operands on acceptance, advance one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_cnt <= '0;
        end else if (i_step) begin
            r_rem <= o_rem_next;
            r_quo <= o_quo_next;
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : int_div_unit
// Description : Iterative RV32M DIV/DIVU/REM/REMU unit. Converts operands to
//               magnitudes, runs the unsigned restoring core for XLEN cycles
//               and applies the sign fix-up on completion. Divide-by-zero and
//               signed overflow finish in one cycle.
//               Optional macro DIV_EARLY_OUT_EN: when defined, operands with
//               |dividend| < |divisor| also finish in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module int_div_unit
    import int_div_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic            CLK,
    input  logic            rst_n,
    input  logic            IDiv,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] Rs1_data,
    input  logic [XLEN-1:0] Rs2_data,
    input  logic            Flush,
    output logic [XLEN-1:0] Div_Result,
    output logic            Div_Done,
    output logic            Div_Stall
);

    localparam logic [XLEN-1:0] c_int_min  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] c_all_ones = {XLEN{1'b1}};

    div_state_t      r_state;
    logic            r_rem_op;
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic            w_s1;
    logic            w_s2;
    logic [XLEN-1:0] w_mag1;
    logic [XLEN-1:0] w_mag2;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_early;
    logic            w_special;
    logic            w_accept;
    logic            w_load;
    logic            w_step;
    logic            w_last;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_sel;
    logic            w_neg;
    logic [XLEN-1:0] w_final;
    logic [XLEN-1:0] w_special_result;
    logic            w_unused_f3;

    // Funct3[2] is always set for M-extension divides; the decoder already
    // qualified the request through IDiv.
    assign w_unused_f3 = Funct3[2];

    assign w_signed = ~Funct3[0];
    assign w_s1     = w_signed & Rs1_data[XLEN-1];
    assign w_s2     = w_signed & Rs2_data[XLEN-1];
    assign w_mag1   = w_s1 ? (~Rs1_data + 1'b1) : Rs1_data;
    assign w_mag2   = w_s2 ? (~Rs2_data + 1'b1) : Rs2_data;

    assign w_div_zero = (Rs2_data == '0);
    assign w_ovf      = w_signed & (Rs1_data == c_int_min) & (Rs2_data == c_all_ones);

`ifdef DIV_EARLY_OUT_EN
    assign w_early = ~w_div_zero & (w_mag1 < w_mag2);
`else
    assign w_early = 1'b0;
`endif

    assign w_special = w_div_zero | w_ovf | w_early;
    assign w_accept  = IDiv & ~Flush & (r_state == IDLE);
    assign w_load    = w_accept & ~w_special;
    assign w_step    = (r_state == CALC);

    // Single-cycle results for the cases that bypass iteration
    always_comb begin
        w_special_result = '0;
        if (w_div_zero) begin
            w_special_result = Funct3[1] ? Rs1_data : c_all_ones;
        end else if (w_ovf) begin
            w_special_result = Funct3[1] ? '0 : c_int_min;
        end else if (w_early) begin
            w_special_result = Funct3[1] ? Rs1_data : '0;
        end
    end

    int_div_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk        (CLK),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend (w_mag1),
        .i_divisor  (w_mag2),
        .o_rem_next (w_rem_next),
        .o_quo_next (w_quo_next),
        .o_last     (w_last)
    );

    assign w_sel   = r_rem_op ? w_rem_next : w_quo_next;
    assign w_neg   = r_rem_op ? r_r_neg : r_q_neg;
    assign w_final = w_neg ? (~w_sel + 1'b1) : w_sel;

    // Control FSM: accept, iterate, then present the result for one cycle
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_rem_op <= 1'b0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rem_op <= Funct3[1];
                        r_q_neg  <= w_s1 ^ w_s2;
                        r_r_neg  <= w_s1;
                        if (w_special) begin
                            r_result <= w_special_result;
                            r_done   <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            r_state  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (Flush) begin
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_result <= w_final;
                        r_done   <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Div_Result = r_result;
    // A flush landing on the completion cycle kills the strobe
    assign Div_Done   = r_done & ~Flush;
    // Reset forces the stall low even while a request is still presented
    assign Div_Stall  = rst_n & ((IDiv & (r_state == IDLE) & ~Flush) | (r_state == CALC));

endmodule
`default_nettype wire

// File: tb/tb_int_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_div_unit
// Description : Self-checking bench for int_div_unit. Directed RV32M cases
//               plus randomized operands checked against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_div_unit;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        IDiv;
    logic [2:0]  Funct3;
    logic [31:0] Rs1_data;
    logic [31:0] Rs2_data;
    logic        Flush;
    logic [31:0] Div_Result;
    logic        Div_Done;
    logic        Div_Stall;

    int checks = 0;
    int errors = 0;

    int_div_unit dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .IDiv       (IDiv),
        .Funct3     (Funct3),
        .Rs1_data   (Rs1_data),
        .Rs2_data   (Rs2_data),
        .Flush      (Flush),
        .Div_Result (Div_Result),
        .Div_Done   (Div_Done),
        .Div_Stall  (Div_Stall)
    );

    always #5 CLK = ~CLK;

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a;
        end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else if (!f3[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b; r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma, mb;
        ma = (!f3[0] && a[31]) ? 32'(-a) : a;
        mb = (!f3[0] && b[31]) ? 32'(-b) : b;
        if (b == 32'd0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb && ma == 32'hDEAD_BEEF) return 33;
`endif
        return 33;
    endfunction

    // Present one request in cycle 0, then scramble operands while it runs.
    // Returns the observed result, done cycle (-1 on timeout) and stall faults.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int stall_bad);
        res = 32'd0; lat = -1; stall_bad = 0;
        @(posedge CLK); #1;
        Funct3 = f3; Rs1_data = a; Rs2_data = b; IDiv = 1'b1; Flush = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge CLK);
            if (Div_Done === 1'b1) begin
                if (Div_Stall !== 1'b0) stall_bad++;
                res = Div_Result;
                lat = c;
                break;
            end
            if (Div_Stall !== 1'b1) stall_bad++;
            @(posedge CLK); #1;
            Rs1_data = $urandom; Rs2_data = $urandom;
        end
    endtask

    task automatic go_idle();
        @(posedge CLK); #1;
        IDiv = 1'b0; Flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; IDiv = 1'b0; Flush = 1'b0; Funct3 = 3'b100;
        Rs1_data = 32'd0; Rs2_data = 32'd0;
        #12;
        checks++;
        if (Div_Result !== 32'd0 || Div_Done !== 1'b0 || Div_Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got result=%h done=%b stall=%b, want 0/0/0", Div_Result, Div_Done, Div_Stall);
        end
        @(negedge CLK); rst_n = 1'b1;
        @(negedge CLK);
        checks++;
        if (Div_Done !== 1'b0 || Div_Stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got done=%b stall=%b, want 0/0", Div_Done, Div_Stall);
        end
    endtask

    task automatic test_directed();
        logic [2:0]  f3s [8] = '{3'b100, 3'b110, 3'b100, 3'b101, 3'b111, 3'b100, 3'b110, 3'b111};
        logic [31:0] as  [8] = '{32'd20, 32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000, 32'd5};
        logic [31:0] bs  [8] = '{32'd3, 32'd3, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9};
        logic [31:0] exp [8] = '{32'd6, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0, 32'd5};
        int          elat[8] = '{33, 33, 33, 1, 1, 1, 1, 33};
        logic [31:0] res;
        int          lat, sb;
`ifdef DIV_EARLY_OUT_EN
        elat[7] = 1;
`endif
        for (int i = 0; i < 8; i++) begin
            run_op(f3s[i], as[i], bs[i], res, lat, sb);
            checks++;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h, want %h", i, res, exp[i]);
            end
            checks++;
            if (lat != elat[i]) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d, want %0d", i, lat, elat[i]);
            end
            checks++;
            if (sb != 0) begin
                errors++;
                $display("FAIL directed_stall[%0d]: got %0d bad cycles, want 0", i, sb);
            end
            go_idle();
            @(negedge CLK);
            checks++;
            if (Div_Done !== 1'b0 || Div_Stall !== 1'b0) begin
                errors++;
                $display("FAIL directed_no_restart[%0d]: got done=%b stall=%b, want 0/0", i, Div_Done, Div_Stall);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res;
        int          lat, sb;
        for (int i = 0; i < 40; i++) begin
            f3 = {1'b1, 2'($urandom_range(0, 3))};
            case ($urandom_range(0, 4))
                0: a = 32'h8000_0000;
                1: a = $urandom_range(0, 50);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = $urandom_range(1, 20);
                3: b = 32'($signed(-$urandom_range(1, 20)));
                default: b = $urandom;
            endcase
            run_op(f3, a, b, res, lat, sb);
            checks++;
            if (res !== ref_result(f3, a, b)) begin
                errors++;
                $display("FAIL random_result f3=%b a=%h b=%h: got %h, want %h", f3, a, b, res, ref_result(f3, a, b));
            end
            checks++;
            if (lat != ref_latency(f3, a, b) || sb != 0) begin
                errors++;
                $display("FAIL random_timing f3=%b a=%h b=%h: got lat=%0d stallbad=%0d, want lat=%0d stallbad=0",
                         f3, a, b, lat, sb, ref_latency(f3, a, b));
            end
            if (i % 3 == 0) go_idle();
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3s [4] = '{3'b101, 3'b110, 3'b100, 3'b111};
        logic [31:0] as  [4] = '{32'd1000, 32'hFFFF_FF00, 32'd77, 32'hFFFF_FFFF};
        logic [31:0] bs  [4] = '{32'd7, 32'd0, 32'hFFFF_FFF9, 32'd16};
        logic [31:0] res;
        int          lat, sb;
        for (int i = 0; i < 4; i++) begin
            run_op(f3s[i], as[i], bs[i], res, lat, sb);
            checks++;
            if (res !== ref_result(f3s[i], as[i], bs[i]) || lat != ref_latency(f3s[i], as[i], bs[i]) || sb != 0) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got res=%h lat=%0d stallbad=%0d, want res=%h lat=%0d stallbad=0",
                         i, res, lat, sb, ref_result(f3s[i], as[i], bs[i]), ref_latency(f3s[i], as[i], bs[i]));
            end
        end
        go_idle();
    endtask

    task automatic test_flush();
        int seen_done, seen_stall;
        @(posedge CLK); #1;
        Funct3 = 3'b101; Rs1_data = 32'd100; Rs2_data = 32'd7; IDiv = 1'b1; Flush = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge CLK); #1;
            if (c == 10) Flush = 1'b1;
        end
        @(negedge CLK);
        checks++;
        if (Div_Done !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle10_done: got %b, want 0", Div_Done);
        end
        @(posedge CLK); #1;
        Flush = 1'b0; IDiv = 1'b0;
        seen_done = 0; seen_stall = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (Div_Done === 1'b1) seen_done++;
            if (Div_Stall === 1'b1) seen_stall++;
        end
        checks++;
        if (seen_done != 0 || seen_stall != 0) begin
            errors++;
            $display("FAIL flush_calc: got done_cycles=%0d stall_cycles=%0d, want 0/0", seen_done, seen_stall);
        end
        // Flush together with a request in IDLE blocks acceptance
        @(posedge CLK); #1;
        IDiv = 1'b1; Flush = 1'b1;
        @(negedge CLK);
        checks++;
        if (Div_Stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_stall: got %b, want 0", Div_Stall);
        end
        @(posedge CLK); #1;
        IDiv = 1'b0; Flush = 1'b0;
        @(negedge CLK);
        checks++;
        if (Div_Stall !== 1'b0 || Div_Done !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_accept: got stall=%b done=%b, want 0/0", Div_Stall, Div_Done);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int          lat, sb;
        @(posedge CLK); #1;
        Funct3 = 3'b101; Rs1_data = 32'd100; Rs2_data = 32'd7; IDiv = 1'b1; Flush = 1'b0;
        repeat (5) @(posedge CLK);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (Div_Result !== 32'd0 || Div_Done !== 1'b0 || Div_Stall !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got result=%h done=%b stall=%b, want 0/0/0", Div_Result, Div_Done, Div_Stall);
        end
        @(negedge CLK); IDiv = 1'b0;
        @(negedge CLK); rst_n = 1'b1;
        run_op(3'b100, 32'd20, 32'd3, res, lat, sb);
        checks++;
        if (res !== 32'd6 || lat != 33) begin
            errors++;
            $display("FAIL post_reset_div: got res=%h lat=%0d, want 00000006 lat=33", res, lat);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
